// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit. Shift-add multiply and
//            restoring divide on operand magnitudes, one bit per cycle,
//            with a single-cycle fast path for divide-by-zero and the signed
//            overflow case.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [2:0] c_MUL    = 3'b000;
    localparam logic [2:0] c_MULH   = 3'b001;
    localparam logic [2:0] c_MULHSU = 3'b010;
    localparam logic [2:0] c_DIV    = 3'b100;
    localparam logic [2:0] c_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_load;

    logic [2:0]  r_funct3;
    logic [31:0] r_ma;       // multiplicand, or dividend shifting into quotient
    logic [31:0] r_mb;       // multiplier shifting right, or divisor
    logic [63:0] r_acc;      // product, or remainder in the upper half
    logic [4:0]  r_cnt;
    logic        r_neg;      // final product/quotient needs negation
    logic        r_neg_rem;  // remainder takes the dividend's sign
    logic [31:0] r_result;

    // ---------------- start-time decode ----------------
    logic        w_a_signed, w_b_signed, w_sign_a, w_sign_b;
    logic [31:0] w_mag_a, w_mag_b;
    logic        w_div_zero, w_ovf, w_fast;
    logic [31:0] w_fast_res;

    assign w_a_signed = (funct3 == c_MUL) || (funct3 == c_MULH) || (funct3 == c_MULHSU)
                      || (funct3 == c_DIV) || (funct3 == c_REM);
    assign w_b_signed = (funct3 == c_MUL) || (funct3 == c_MULH)
                      || (funct3 == c_DIV) || (funct3 == c_REM);
    assign w_sign_a   = w_a_signed & op_a[31];
    assign w_sign_b   = w_b_signed & op_b[31];
    assign w_mag_a    = w_sign_a ? (~op_a + 32'd1) : op_a;
    assign w_mag_b    = w_sign_b ? (~op_b + 32'd1) : op_b;

    assign w_div_zero = funct3[2] && (op_b == 32'd0);
    assign w_ovf      = ((funct3 == c_DIV) || (funct3 == c_REM))
                      && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign w_fast     = w_div_zero | w_ovf;
    // funct3[1] distinguishes the remainder forms among divides
    assign w_fast_res = w_div_zero ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                                   : (funct3[1] ? 32'd0 : 32'h8000_0000);

    // ---------------- per-iteration datapath ----------------
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_acc;
    logic [32:0] w_rem_sh;
    logic [33:0] w_diff;
    logic        w_ge;
    logic [31:0] w_div_rem, w_div_q;
    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem, w_final;

    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_mb[0] ? {1'b0, r_ma} : 33'd0);
    assign w_mul_acc = {w_mul_sum, r_acc[31:1]};

    assign w_rem_sh  = {r_acc[63:32], r_ma[31]};
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_mb};
    assign w_ge      = ~w_diff[33];
    assign w_div_rem = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_div_q   = {r_ma[30:0], w_ge};

    assign w_prod    = r_neg     ? (~w_mul_acc + 64'd1) : w_mul_acc;
    assign w_quot    = r_neg     ? (~w_div_q + 32'd1)   : w_div_q;
    assign w_rem     = r_neg_rem ? (~w_div_rem + 32'd1) : w_div_rem;

    // Result select for the final iteration, sign fix-up already applied
    always_comb begin
        w_final = w_prod[63:32];
        case (r_funct3)
            3'b000:        w_final = w_prod[31:0];
            3'b100, 3'b101: w_final = w_quot;
            3'b110, 3'b111: w_final = w_rem;
            default:       w_final = w_prod[63:32];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC:  if (r_cnt == 5'd31) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand load, iteration and result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_funct3  <= 3'd0;
            r_ma      <= 32'd0;
            r_mb      <= 32'd0;
            r_acc     <= 64'd0;
            r_cnt     <= 5'd0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= 32'd0;
        end else if (w_load) begin
            r_funct3  <= funct3;
            r_ma      <= w_mag_a;
            r_mb      <= w_mag_b;
            r_acc     <= 64'd0;
            r_cnt     <= 5'd0;
            r_neg     <= w_sign_a ^ w_sign_b;
            r_neg_rem <= w_sign_a;
            if (w_fast) r_result <= w_fast_res;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_funct3[2]) begin
                r_acc <= {w_div_rem, 32'd0};
                r_ma  <= w_div_q;
            end else begin
                r_acc <= w_mul_acc;
                r_mb  <= {1'b0, r_mb[31:1]};
            end
            if (r_cnt == 5'd31) r_result <= w_final;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage of the no-pipeline core, directly downstream of the ID-stage register file. It takes the two register read values (rs1, rs2) plus the instruction's funct3, computes the 32-bit M-extension result in a bounded number of cycles, and presents it for write-back to the register file's data input. The core stalls on `busy` and writes back on the `done` pulse.

## Interface
- No parameters; datapath width fixed at 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start` input 1: request; sampled only in IDLE.
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` input 32: rs1 value (register file read port one).
- `op_b` input 32: rs2 value (register file read port two).
- `busy` output 1: high in CALC and DONE; the core holds the instruction while high.
- `done` output 1: one-cycle pulse; `result` valid in the same cycle.
- `result` output 32: registered result; held until the next accepted `start`.

## Operation
- State machine IDLE -> CALC -> DONE -> IDLE. The fast path goes IDLE -> DONE.
- IDLE with `start`=1: latch `funct3`; latch operand magnitudes and sign flags; clear the 64-bit accumulator and the 5-bit counter.
  - Signedness: `op_a` signed for MUL, MULH, MULHSU, DIV, REM. `op_b` signed for MUL, MULH, DIV, REM.
  - MUL low word is sign-agnostic.
  - Next state is CALC, or DONE on the fast path.
- Fast path, decided at start:
  - DIV/DIVU with `op_b`=0: result 0xFFFFFFFF.
  - REM/REMU with `op_b`=0: result `op_a`.
  - DIV with 0x80000000 / 0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- CALC, multiply: shift-add on the unsigned magnitudes, one multiplier bit per cycle, 32 cycles.
  - Final 64-bit product is negated when the operand signs differ (signed forms only).
  - MUL returns product[31:0]; MULH, MULHSU, MULHU return product[63:32].
- CALC, divide: restoring division on the magnitudes, one quotient bit per cycle, 32 cycles.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Counter reaches 31 in CALC: sign fix-up is applied, `result` is registered, next state is DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` while not IDLE is ignored, with no effect on the operation in flight.
- All arithmetic is modulo 2^32 on the output; no exceptions or flags.

## Timing
- Reset (`reset`=0 at an edge), takes priority over everything:
  - State goes to IDLE.
  - `busy`=0, `done`=0, `result`=0x00000000.
  - Counter and accumulator are cleared.
  - An operation in flight is abandoned and produces no `done`.
- Normal path, with edge E1 sampling `start` in IDLE:
  - E1: load operands; `busy`=1 after E1.
  - E2..E33: 32 iterations.
  - After E33: `done`=1 and `result` valid.
  - After E34: `done`=0, `busy`=0.
  - Latency from start to done is 33 cycles.
- Fast path: `done`=1 and `result` valid after E1; `busy`=0 after E2. Latency is 1 cycle.
- Earliest next `start` is sampled at the edge that returns the unit to IDLE plus one (E35 on the normal path), i.e. the first edge at which `busy`=0.
- Operands are needed only at E1; `op_a`/`op_b` may change afterwards.
- `result` stays stable from `done` until the next accepted start's completion register update. It is not cleared between operations.

## Test plan
- Reset mid-operation: start MUL 7*6, assert `reset`=0 at E10 -> `busy`=0, `result`=0 next cycle, no `done` pulse. A fresh MUL 7*6 then gives `done` at +33 with `result`=0x0000002A.
- Multiply forms with `op_a`=0xFFFFFFFF, `op_b`=0x00000002:
  - MUL -> 0xFFFFFFFE
  - MULH -> 0xFFFFFFFF
  - MULHSU -> 0xFFFFFFFF
  - MULHU -> 0x00000001
  - Each with `done` exactly 33 cycles after the start edge.
- Signed division with `op_a`=0xFFFFFFF9 (-7), `op_b`=2:
  - DIV -> 0xFFFFFFFD
  - REM -> 0xFFFFFFFF
  - DIVU -> 0x7FFFFFFC
  - REMU -> 0x00000001
- Fast path, each with `done` 1 cycle after start:
  - DIV 5/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 0x00000005
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM same operands -> 0x00000000
- Start while busy: pulse `start` with new operands at E5 and at the DONE cycle -> ignored; `result` matches the first operation; only one `done` pulse.
- Back-to-back operations: assert `start` at the first edge `busy`=0 after a DIVU 100/7 (result 14) -> accepted; the next REMU 100/7 gives `result`=2, with `done` 33 cycles later.
